// File: rtl/harm_note_seq.sv
// harm_note_seq: takes one piano note per request and emits NUM_HARM harmonic
// note indices (one per output handshake) for the shared FCW lookup/oscillator
// bank. Each slot adds a signed semitone offset and can be silenced by the
// drawbar mask or by leaving the legal note range.
module harm_note_seq #(
    parameter int                        NUM_HARM = 3,
    parameter int                        NOTE_W   = 7,
    parameter int                        OFF_W    = 6,
    parameter logic [NUM_HARM*OFF_W-1:0] OFFSETS  = {6'sd7, 6'sd0, -6'sd12},
    parameter int                        NOTE_MIN = 1,
    parameter int                        NOTE_MAX = 88,
    parameter int                        SILENT   = 127,
    localparam int                       IDX_W    = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NOTE_W-1:0]   in_note,
    input  logic [NUM_HARM-1:0] harm_mask,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NOTE_W-1:0]   out_note,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_last
);

    // Two extra bits hold the zero-extended note plus a signed offset without wrapping.
    localparam int SUM_W = NOTE_W + 2;

    localparam logic signed [SUM_W-1:0] MinNote    = SUM_W'(NOTE_MIN);
    localparam logic signed [SUM_W-1:0] MaxNote    = SUM_W'(NOTE_MAX);
    localparam logic [NOTE_W-1:0]       SilentNote = NOTE_W'(SILENT);
    localparam logic [IDX_W-1:0]        LastIdx    = IDX_W'(NUM_HARM - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                state_q;
    logic [NOTE_W-1:0]     note_q;
    logic [NUM_HARM-1:0]   mask_q;
    logic                  outValid_q;
    logic [NOTE_W-1:0]     outNote_q;
    logic [IDX_W-1:0]      outIdx_q;
    logic                  outLast_q;

    logic [IDX_W-1:0]      slotIdx_d;
    logic [NOTE_W-1:0]     slotNote_d;

    // Harmonic note for one slot; any out-of-range input or result becomes SILENT.
    function automatic logic [NOTE_W-1:0] slotNote(
        input logic [NOTE_W-1:0]   note,
        input logic [NUM_HARM-1:0] mask,
        input logic [IDX_W-1:0]    slot
    );
        logic signed [OFF_W-1:0] offset;
        logic signed [SUM_W-1:0] noteS;
        logic signed [SUM_W-1:0] sum;
        offset = OFFSETS[int'(slot)*OFF_W +: OFF_W];
        noteS  = $signed({2'b00, note});
        sum    = noteS + SUM_W'(offset);
        if ((noteS < MinNote) || (noteS > MaxNote) || !mask[slot] ||
            (sum < MinNote) || (sum > MaxNote)) begin
            return SilentNote;
        end
        return sum[NOTE_W-1:0];
    endfunction

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = outValid_q;
    assign out_note  = outNote_q;
    assign out_idx   = outIdx_q;
    assign out_last  = outLast_q;

    // Select the slot to load next: slot 0 of the incoming note, or the following slot of the captured note.
    always_comb begin
        slotIdx_d  = '0;
        slotNote_d = SilentNote;
        if (state_q == IDLE) begin
            slotIdx_d  = '0;
            slotNote_d = slotNote(in_note, harm_mask, '0);
        end else begin
            slotIdx_d  = outIdx_q + IDX_W'(1);
            slotNote_d = slotNote(note_q, mask_q, slotIdx_d);
        end
    end

    // Sequencer: accept a note in IDLE, then step through every slot on each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            note_q     <= SilentNote;
            mask_q     <= '0;
            outValid_q <= 1'b0;
            outNote_q  <= SilentNote;
            outIdx_q   <= '0;
            outLast_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        note_q     <= in_note;
                        mask_q     <= harm_mask;
                        outValid_q <= 1'b1;
                        outNote_q  <= slotNote_d;
                        outIdx_q   <= '0;
                        outLast_q  <= (NUM_HARM == 1);
                        state_q    <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (outLast_q) begin
                            outValid_q <= 1'b0;
                            outNote_q  <= SilentNote;
                            outIdx_q   <= '0;
                            outLast_q  <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            outNote_q <= slotNote_d;
                            outIdx_q  <= slotIdx_d;
                            outLast_q <= (slotIdx_d == LastIdx);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_harm_note_seq.sv
// tb_harm_note_seq: table-driven vectors and hand-written sequences for
// harm_note_seq, with expected beats queued at note acceptance and compared
// as the DUT hands them downstream.
module tb_harm_note_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_note;
    logic [2:0] harm_mask;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_note;
    logic [1:0] out_idx;
    logic       out_last;

    int vectors    = 0;
    int miscompares = 0;
    bit stallMode  = 1'b0;

    typedef struct {
        logic [6:0]      note;
        logic [2:0]      mask;
        logic [2:0][6:0] exp;
    } vec_t;

    typedef struct {
        logic [6:0] note;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    beat_t sb[$];
    vec_t  vecTable[13];

    harm_note_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_note   (in_note),
        .harm_mask (harm_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_note  (out_note),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Compare one value and report any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: default offsets -12, 0, +7 and legal range 1..88.
    function automatic logic [2:0][6:0] modelNote(input int note, input logic [2:0] mask);
        int offs[3] = '{-12, 0, 7};
        int s;
        logic [2:0][6:0] r;
        for (int i = 0; i < 3; i++) begin
            s = note + offs[i];
            if (note < 1 || note > 88 || !mask[i] || s < 1 || s > 88) r[i] = 7'd127;
            else r[i] = 7'(s);
        end
        return r;
    endfunction

    // Present a note, wait (bounded) for acceptance and queue its three expected beats.
    task automatic applyStimulus(input logic [6:0] note, input logic [2:0] mask, input logic [2:0][6:0] exp);
        bit    accepted = 1'b0;
        beat_t b;
        in_valid  = 1'b1;
        in_note   = note;
        harm_mask = mask;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    b.note = exp[i];
                    b.idx  = 2'(i);
                    b.last = (i == 2);
                    sb.push_back(b);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("note accepted", 32'(accepted), 1);
    endtask

    // Wait (bounded) until every queued beat has been delivered and the output is idle.
    task automatic waitDrain();
        for (int c = 0; c < 300; c++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drain pending beats", 32'(sb.size()), 0);
        checkOutput("drain out_valid", 32'(out_valid), 0);
    endtask

    // Scoreboard monitor: pops on every handshake and checks that stalled outputs hold.
    logic       stallSeen = 1'b0;
    logic [9:0] heldBeat  = '0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stallSeen = 1'b0;
        end else begin
            if (stallSeen && out_valid) checkOutput("stall hold", {out_note, out_idx, out_last}, 32'(heldBeat));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected beat queue depth", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("beat%0d note", e.idx), 32'(out_note), 32'(e.note));
                    checkOutput($sformatf("beat%0d idx", e.idx), 32'(out_idx), 32'(e.idx));
                    checkOutput($sformatf("beat%0d last", e.idx), 32'(out_last), 32'(e.last));
                end
            end
            stallSeen = out_valid && !out_ready;
            heldBeat  = {out_note, out_idx, out_last};
        end
    end

    // Random downstream back-pressure while stall mode is enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stallMode) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Main test sequence.
    initial begin
        int         rn;
        logic [2:0] rm;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_note   = '0;
        harm_mask = '0;
        out_ready = 1'b1;

        vecTable[0]  = '{7'd40, 3'b111, {7'd47,  7'd40,  7'd28}};
        vecTable[1]  = '{7'd5,  3'b111, {7'd12,  7'd5,   7'd127}};
        vecTable[2]  = '{7'd85, 3'b111, {7'd127, 7'd85,  7'd73}};
        vecTable[3]  = '{7'd13, 3'b111, {7'd20,  7'd13,  7'd1}};
        vecTable[4]  = '{7'd81, 3'b111, {7'd88,  7'd81,  7'd69}};
        vecTable[5]  = '{7'd0,  3'b111, {7'd127, 7'd127, 7'd127}};
        vecTable[6]  = '{7'd89, 3'b111, {7'd127, 7'd127, 7'd127}};
        vecTable[7]  = '{7'd40, 3'b010, {7'd127, 7'd40,  7'd127}};
        vecTable[8]  = '{7'd12, 3'b111, {7'd19,  7'd12,  7'd127}};
        vecTable[9]  = '{7'd1,  3'b111, {7'd8,   7'd1,   7'd127}};
        vecTable[10] = '{7'd88, 3'b111, {7'd127, 7'd88,  7'd76}};
        vecTable[11] = '{7'd82, 3'b111, {7'd127, 7'd82,  7'd70}};
        vecTable[12] = '{7'd40, 3'b101, {7'd47,  7'd127, 7'd28}};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 0);
        checkOutput("reset out_note", 32'(out_note), 127);
        checkOutput("reset out_idx", 32'(out_idx), 0);
        checkOutput("reset out_last", 32'(out_last), 0);
        checkOutput("reset in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready after reset", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Throughput: three beats back to back, in_ready returns the cycle after the last.
        applyStimulus(7'd40, 3'b111, vecTable[0].exp);
        checkOutput("busy in_ready", 32'(in_ready), 0);
        checkOutput("first beat valid", 32'(out_valid), 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("last beat flag", 32'(out_last), 1);
        checkOutput("in_ready on last beat", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        checkOutput("in_ready after last", 32'(in_ready), 1);
        checkOutput("out_valid after last", 32'(out_valid), 0);

        // Table vectors, back to back.
        foreach (vecTable[k]) applyStimulus(vecTable[k].note, vecTable[k].mask, vecTable[k].exp);
        waitDrain();

        // Random notes and masks against the reference model.
        for (int k = 0; k < 8; k++) begin
            rn = int'($urandom_range(0, 95));
            rm = 3'($urandom_range(0, 7));
            applyStimulus(7'(rn), rm, modelNote(rn, rm));
        end
        waitDrain();

        // Random back-pressure; the second request is held during EMIT and taken once idle.
        stallMode = 1'b1;
        applyStimulus(7'd40, 3'b111, vecTable[0].exp);
        applyStimulus(7'd50, 3'b111, modelNote(50, 3'b111));
        waitDrain();
        stallMode = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Reset in the middle of a note discards the remaining beats.
        applyStimulus(7'd40, 3'b111, vecTable[0].exp);
        @(posedge clk);
        #1;
        checkOutput("beats left after beat0", 32'(sb.size()), 2);
        rst = 1'b1;
        #1;
        checkOutput("mid rst out_valid", 32'(out_valid), 0);
        checkOutput("mid rst out_note", 32'(out_note), 127);
        checkOutput("mid rst out_idx", 32'(out_idx), 0);
        checkOutput("mid rst in_ready", 32'(in_ready), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready after mid rst", 32'(in_ready), 1);
        checkOutput("out_valid after mid rst", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        // Normal operation resumes after the reset.
        applyStimulus(7'd81, 3'b111, vecTable[4].exp);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
